// File: rtl/vga_fb_pkg.sv
// Shared types and constants for the double-buffered VGA framebuffer.
// Holds the FSM state encoding, the register offsets, and the bit positions
// of the CTRL and STATUS fields.
package vga_fb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } fb_state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CLRCOL = 2'd2;

    localparam int unsigned CTRL_SWAP_BIT  = 0;
    localparam int unsigned CTRL_CLEAR_BIT = 1;

    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_PEND_BIT  = 1;
    localparam int unsigned STAT_FRONT_BIT = 2;
    localparam int unsigned STAT_AERR_BIT  = 3;

endpackage

// File: rtl/fb_bank_ram.sv
// One framebuffer bank: simple dual-port synchronous RAM.
// Ports: clk; i_we/i_waddr/i_wdata write port; i_re/i_raddr read request;
// o_rdata registered read data (holds when i_re is low).
module fb_bank_ram #(
    parameter int unsigned DEPTH = 307200,
    parameter int unsigned WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Contents deliberately have no reset; the clear engine initialises them.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vga_fb_dbuf.sv
// Double-buffered framebuffer with an Avalon-MM host port and a VGA pixel
// read port. Host writes go to the back bank; the front bank feeds the display
// and is never written. Swaps happen only on vsync_pulse; a clear engine fills
// the back bank with CLEAR_COLOR, one pixel per cycle.
// Ports: clk, reset (sync, active high); Avalon chipselect/write/read/address/
// writedata/readdata/waitrequest; VGA pix_x/pix_y/pix_rd/vsync_pulse in,
// pix_rgb/pix_valid out (1-cycle latency).
module vga_fb_dbuf #(
    parameter int unsigned H_RES   = 640,
    parameter int unsigned V_RES   = 480,
    parameter int unsigned PIXEL_W = 24,
    parameter int unsigned ADDR_W  = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               chipselect,
    input  logic               write,
    input  logic               read,
    input  logic [ADDR_W-1:0]  address,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               waitrequest,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    input  logic               pix_rd,
    input  logic               vsync_pulse,
    output logic [PIXEL_W-1:0] pix_rgb,
    output logic               pix_valid
);
    import vga_fb_pkg::*;

    localparam int unsigned NPIX  = H_RES * V_RES;
    localparam int unsigned IDX_W = $clog2(NPIX);
    localparam int unsigned PA_W  = ADDR_W - 1;

    fb_state_t          r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_front, r_swap_pend, r_addr_err;
    logic [PIXEL_W-1:0] r_clr_col;
    logic [31:0]        r_readdata;
    logic               r_pix_valid, r_rd_oor, r_rd_bank;

    // Avalon decode
    logic            w_is_reg, w_pix_ok, w_busy, w_stall;
    logic            w_wr_acc, w_rd_acc, w_reg_wr, w_pix_wr, w_pix_err;
    logic            w_swap_req, w_clear_req;
    logic [PA_W-1:0] w_pix_idx;
    logic            w_unused_wdata;

    assign w_is_reg    = address[ADDR_W-1];
    assign w_pix_idx   = address[PA_W-1:0];
    assign w_pix_ok    = w_pix_idx < PA_W'(NPIX);
    assign w_busy      = (r_state == CLEAR);
    assign w_stall     = chipselect & (write | read) & w_busy & ~w_is_reg;
    assign w_wr_acc    = chipselect & write & ~w_stall;
    assign w_rd_acc    = chipselect & read & ~write & ~w_stall;
    assign w_reg_wr    = w_wr_acc & w_is_reg;
    assign w_pix_wr    = w_wr_acc & ~w_is_reg & w_pix_ok;
    assign w_pix_err   = w_wr_acc & ~w_is_reg & ~w_pix_ok;
    assign w_swap_req  = w_reg_wr & (address[1:0] == REG_CTRL) & writedata[CTRL_SWAP_BIT];
    assign w_clear_req = w_reg_wr & (address[1:0] == REG_CTRL) & writedata[CTRL_CLEAR_BIT];
    assign w_unused_wdata = ^writedata[31:PIXEL_W];

    assign waitrequest = w_stall;

    // Next-state logic for the clear / swap sequencer
    logic w_clr_we, w_front_tgl;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_we    = 1'b0;
        w_front_tgl = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Clear has priority; a simultaneous swap is parked in SWAP_PEND.
                if (w_clear_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end else if (w_swap_req) begin
                    w_state_nxt = SWAP_WAIT;
                end
            end
            CLEAR: begin
                w_clr_we = 1'b1;
                if (r_cnt == IDX_W'(NPIX - 1)) begin
                    w_state_nxt = (r_swap_pend | w_swap_req) ? SWAP_WAIT : IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + IDX_W'(1);
                end
            end
            SWAP_WAIT: begin
                if (vsync_pulse) begin
                    w_front_tgl = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Control/status registers and register read-back
    always_ff @(posedge clk) begin
        if (reset) begin
            r_front     <= 1'b0;
            r_swap_pend <= 1'b0;
            r_addr_err  <= 1'b0;
            r_clr_col   <= '0;
            r_readdata  <= '0;
        end else begin
            if (w_front_tgl) r_front <= ~r_front;

            if (w_front_tgl)     r_swap_pend <= 1'b0;
            else if (w_swap_req) r_swap_pend <= 1'b1;

            if (w_pix_err)
                r_addr_err <= 1'b1;
            else if (w_reg_wr && address[1:0] == REG_STATUS && writedata[STAT_AERR_BIT])
                r_addr_err <= 1'b0;

            if (w_reg_wr && address[1:0] == REG_CLRCOL)
                r_clr_col <= writedata[PIXEL_W-1:0];

            if (w_rd_acc) begin
                if (!w_is_reg) begin
                    r_readdata <= '0;
                end else begin
                    unique case (address[1:0])
                        REG_STATUS: r_readdata <= {28'd0, r_addr_err, r_front, r_swap_pend, w_busy};
                        REG_CLRCOL: r_readdata <= 32'(r_clr_col);
                        default:    r_readdata <= '0;
                    endcase
                end
            end
        end
    end

    assign readdata = r_readdata;

    // Back-bank write port: clear engine owns it while busy (host is stalled then)
    logic               w_bk_we;
    logic [IDX_W-1:0]   w_bk_addr;
    logic [PIXEL_W-1:0] w_bk_data;

    assign w_bk_we   = w_clr_we | w_pix_wr;
    assign w_bk_addr = w_clr_we ? r_cnt : IDX_W'(w_pix_idx);
    assign w_bk_data = w_clr_we ? r_clr_col : writedata[PIXEL_W-1:0];

    // Pixel read side
    logic               w_rd_in, w_rd_en;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [PIXEL_W-1:0] w_q0, w_q1;

    assign w_rd_in  = (pix_x < 10'(H_RES)) & (pix_y < 10'(V_RES));
    assign w_rd_idx = IDX_W'(pix_y) * IDX_W'(H_RES) + IDX_W'(pix_x);
    assign w_rd_en  = pix_rd & w_rd_in;

    fb_bank_ram #(.DEPTH(NPIX), .WIDTH(PIXEL_W)) u_bank0 (
        .clk(clk), .i_we(w_bk_we & r_front), .i_waddr(w_bk_addr), .i_wdata(w_bk_data),
        .i_re(w_rd_en), .i_raddr(w_rd_idx), .o_rdata(w_q0)
    );

    fb_bank_ram #(.DEPTH(NPIX), .WIDTH(PIXEL_W)) u_bank1 (
        .clk(clk), .i_we(w_bk_we & ~r_front), .i_waddr(w_bk_addr), .i_wdata(w_bk_data),
        .i_re(w_rd_en), .i_raddr(w_rd_idx), .o_rdata(w_q1)
    );

    // Bank and range of the last accepted read are captured so pix_rgb holds
    // steady between reads even across a swap; oor resets high so pix_rgb=0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_valid <= 1'b0;
            r_rd_oor    <= 1'b1;
            r_rd_bank   <= 1'b0;
        end else begin
            r_pix_valid <= pix_rd;
            if (pix_rd) begin
                r_rd_oor  <= ~w_rd_in;
                r_rd_bank <= r_front;
            end
        end
    end

    assign pix_valid = r_pix_valid;
    assign pix_rgb   = r_rd_oor ? '0 : (r_rd_bank ? w_q1 : w_q0);

endmodule

// File: tb/tb_vga_fb_dbuf.sv
// Directed testbench for vga_fb_dbuf, using a reduced 8x4 frame (32 pixels).
module tb_vga_fb_dbuf;

    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned NP = H * V;
    localparam logic [19:0] RB = 20'h80000;

    logic        clk, reset;
    logic        chipselect, write, read;
    logic [19:0] address;
    logic [31:0] writedata, readdata;
    logic        waitrequest;
    logic [9:0]  pix_x, pix_y;
    logic        pix_rd, vsync_pulse;
    logic [23:0] pix_rgb;
    logic        pix_valid;

    int n_tests = 0;
    int n_fail  = 0;

    vga_fb_dbuf #(.H_RES(H), .V_RES(V), .PIXEL_W(24), .ADDR_W(20)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
        .address(address), .writedata(writedata), .readdata(readdata),
        .waitrequest(waitrequest), .pix_x(pix_x), .pix_y(pix_y), .pix_rd(pix_rd),
        .vsync_pulse(vsync_pulse), .pix_rgb(pix_rgb), .pix_valid(pix_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic av_write(input logic [19:0] a, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        #1;
        while (waitrequest && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL av_write_timeout: addr=%h still stalled after %0d cycles", a, n);
        end
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic av_read(input logic [19:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic vsync_once();
        @(negedge clk); vsync_pulse = 1'b1;
        @(negedge clk); vsync_pulse = 1'b0;
    endtask

    task automatic pix_read(input int x, input int y, output logic [23:0] rgb, output logic v);
        @(negedge clk);
        pix_rd = 1'b1; pix_x = 10'(x); pix_y = 10'(y);
        @(negedge clk);
        pix_rd = 1'b0;
        rgb = pix_rgb; v = pix_valid;
    endtask

    // Holds a pixel write on the bus while clearing and counts stalled cycles.
    task automatic count_busy(input logic [19:0] a, input logic [31:0] d,
                              output int n, output logic first);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        n = 0;
        @(negedge clk);
        first = waitrequest;
        while (waitrequest && n < 200) begin
            n++; @(negedge clk);
        end
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [23:0] rgb; logic v;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_tests++;
        if ({readdata, pix_rgb, pix_valid, waitrequest} !== 58'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rd=%h rgb=%h v=%b wr=%b, want all 0",
                     readdata, pix_rgb, pix_valid, waitrequest);
        end
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", d); end
        pix_read(0, 0, rgb, v);
        n_tests++;
        if (v !== 1'b1) begin n_fail++; $display("FAIL reset_pix_valid: got %b want 1", v); end
        @(negedge clk);
        n_tests++;
        if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL pix_valid_idle: got %b want 0", pix_valid); end
        pix_read(H, 0, rgb, v);
        n_tests++;
        if ({rgb, v} !== {24'h0, 1'b1}) begin
            n_fail++; $display("FAIL pix_oor: got rgb=%h v=%b want 000000/1", rgb, v);
        end
    endtask

    task automatic test_clear();
        logic [31:0] d; logic [23:0] rgb; logic v; int n; logic first;
        av_write(RB | 20'd2, 32'h0000FF00);
        av_read(RB | 20'd2, d);
        n_tests++;
        if (d !== 32'h0000FF00) begin n_fail++; $display("FAIL clrcol_rb: got %h want 0000ff00", d); end
        av_write(RB | 20'd0, 32'h2);
        count_busy(20'd5, 32'h00ABCDEF, n, first);
        n_tests++;
        if (first !== 1'b1) begin n_fail++; $display("FAIL clear_stall: waitrequest=%b want 1", first); end
        n_tests++;
        if (n != NP) begin n_fail++; $display("FAIL clear_len: busy %0d cycles want %0d", n, NP); end
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL clear_done_status: got %h want 0", d); end
        av_write(RB | 20'd0, 32'h1);
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL swap_pend: got %h want 2", d); end
        vsync_once();
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL swap_front1: got %h want 4", d); end
        pix_read(H - 1, V - 1, rgb, v);
        n_tests++;
        if ({rgb, v} !== {24'h00FF00, 1'b1}) begin
            n_fail++; $display("FAIL clear_last_pix: got %h/%b want 00ff00/1", rgb, v);
        end
        @(negedge clk);
        n_tests++;
        if ({pix_rgb, pix_valid} !== {24'h00FF00, 1'b0}) begin
            n_fail++; $display("FAIL pix_hold: got %h/%b want 00ff00/0", pix_rgb, pix_valid);
        end
        pix_read(5, 0, rgb, v);
        n_tests++;
        if (rgb !== 24'hABCDEF) begin n_fail++; $display("FAIL stalled_write: got %h want abcdef", rgb); end
    endtask

    task automatic test_swap();
        logic [31:0] d; logic [23:0] rgb; logic v;
        av_write(20'd9, 32'h00123456);
        pix_read(1, 1, rgb, v);
        n_tests++;
        if (rgb !== 24'h00FF00) begin n_fail++; $display("FAIL no_tear_pre: got %h want 00ff00", rgb); end
        av_write(RB | 20'd0, 32'h1);
        pix_read(1, 1, rgb, v);
        n_tests++;
        if (rgb !== 24'h00FF00) begin n_fail++; $display("FAIL no_swap_before_vsync: got %h want 00ff00", rgb); end
        vsync_once();
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL swap_front0: got %h want 0", d); end
        pix_read(1, 1, rgb, v);
        n_tests++;
        if (rgb !== 24'h123456) begin n_fail++; $display("FAIL swap_pixel: got %h want 123456", rgb); end
    endtask

    task automatic test_swap_edges();
        logic [31:0] d;
        // CTRL swap write and vsync pulse in the same cycle
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = RB; writedata = 32'h1; vsync_pulse = 1'b1;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0; vsync_pulse = 1'b0;
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL same_cycle_vsync: got %h want 2", d); end
        av_write(RB | 20'd0, 32'h2);
        av_write(RB | 20'd0, 32'h1);
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h2) begin n_fail++; $display("FAIL req_while_pending: got %h want 2", d); end
        vsync_once();
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL single_toggle: got %h want 4", d); end
        vsync_once();
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL no_double_toggle: got %h want 4", d); end
    endtask

    task automatic test_clear_swap();
        logic [31:0] d; logic [23:0] rgb; logic v; int n;
        av_write(RB | 20'd0, 32'h3);
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h7) begin n_fail++; $display("FAIL clrswap_start: got %h want 7", d); end
        vsync_once();
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h7) begin n_fail++; $display("FAIL vsync_mid_clear: got %h want 7", d); end
        n = 0;
        do begin
            av_read(RB | 20'd1, d); n++;
        end while (d[0] && n < 100);
        n_tests++;
        if (d !== 32'h6) begin n_fail++; $display("FAIL clear_to_swapwait: got %h want 6 (%0d polls)", d, n); end
        vsync_once();
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL clrswap_toggle: got %h want 0", d); end
        vsync_once();
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL clrswap_once: got %h want 0", d); end
        pix_read(1, 1, rgb, v);
        n_tests++;
        if (rgb !== 24'h00FF00) begin n_fail++; $display("FAIL clrswap_pixel: got %h want 00ff00", rgb); end
    endtask

    task automatic test_addr_err();
        logic [31:0] d; logic [23:0] rgb; logic v;
        av_write(20'(NP), 32'h00DEAD00);
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h8) begin n_fail++; $display("FAIL addr_err_set: got %h want 8", d); end
        av_read(20'd3, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL pixel_space_read: got %h want 0", d); end
        av_read(RB | 20'd3, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL reserved_read: got %h want 0", d); end
        av_write(RB | 20'd0, 32'h1);
        vsync_once();
        pix_read(0, 0, rgb, v);
        n_tests++;
        if (rgb !== 24'h00FF00) begin n_fail++; $display("FAIL oor_write_dropped: got %h want 00ff00", rgb); end
        av_write(RB | 20'd1, 32'h8);
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h4) begin n_fail++; $display("FAIL addr_err_clear: got %h want 4", d); end
    endtask

    task automatic test_reset_midclear();
        logic [31:0] d; logic [23:0] rgb; logic v; int n; logic first;
        av_write(RB | 20'd0, 32'h2);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midclear_reset_status: got %h want 0", d); end
        av_read(RB | 20'd2, d);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL midclear_reset_clrcol: got %h want 0", d); end
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = 20'd2; writedata = 32'h00111111;
        #1;
        n_tests++;
        if (waitrequest !== 1'b0) begin n_fail++; $display("FAIL idle_no_stall: got %b want 0", waitrequest); end
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
        av_write(RB | 20'd0, 32'h2);
        count_busy(20'd40, 32'h0, n, first);
        n_tests++;
        if (n != NP) begin n_fail++; $display("FAIL restart_len: busy %0d cycles want %0d", n, NP); end
        av_write(RB | 20'd0, 32'h1);
        vsync_once();
        pix_read(0, 0, rgb, v);
        n_tests++;
        if (rgb !== 24'h0) begin n_fail++; $display("FAIL restart_pix0: got %h want 0", rgb); end
        pix_read(2, 0, rgb, v);
        n_tests++;
        if (rgb !== 24'h0) begin n_fail++; $display("FAIL restart_pix2: got %h want 0", rgb); end
        pix_read(H - 1, V - 1, rgb, v);
        n_tests++;
        if (rgb !== 24'h0) begin n_fail++; $display("FAIL restart_pixlast: got %h want 0", rgb); end
        av_read(RB | 20'd1, d);
        n_tests++;
        if (d !== 32'hC) begin n_fail++; $display("FAIL restart_status: got %h want c", d); end
    endtask

    initial begin
        reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; pix_x = '0; pix_y = '0;
        pix_rd = 1'b0; vsync_pulse = 1'b0;
        test_reset();
        test_clear();
        test_swap();
        test_swap_edges();
        test_clear_swap();
        test_addr_err();
        test_reset_midclear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_fb_dbuf.md
Name: vga_fb_dbuf

Overview:
- Parametrised double-buffered framebuffer; Avalon-MM slave on the host side, pixel read port on the VGA side.
- Host writes pixels into the back buffer. The VGA timing generator reads the front buffer by (x, y).
- Buffer swap is frame-aligned: it takes effect only on a vsync pulse.
- A hardware clear engine fills the back buffer with a programmable colour, one pixel per cycle. This replaces any single-cycle bulk initialisation.

Parameters:
H_RES, 640, active pixels per line
V_RES, 480, active lines per frame
PIXEL_W, 24, bits per pixel (packed RGB, MSB = red)
ADDR_W, 20, Avalon word-address width; bit ADDR_W-1 selects the register space

Ports:
clk  in  1  system clock (single clock domain)
reset  in  1  synchronous, active-high reset
chipselect  in  1  Avalon slave select
write  in  1  Avalon write strobe
read  in  1  Avalon read strobe
address  in  ADDR_W  word address
writedata  in  32  write data; pixel occupies [PIXEL_W-1:0]
readdata  out  32  register read data, valid 1 cycle after an accepted read
waitrequest  out  1  high = transfer not accepted this cycle
pix_x  in  10  requested column
pix_y  in  10  requested row
pix_rd  in  1  pixel read strobe
vsync_pulse  in  1  one-cycle start-of-blanking pulse
pix_rgb  out  PIXEL_W  front-buffer pixel, 1-cycle latency
pix_valid  out  1  pix_rgb qualifier

Behaviour:
- Address map:
  - address[ADDR_W-1]=0: pixel space. Index = address[ADDR_W-2:0] = y*H_RES + x. Valid only when index < H_RES*V_RES.
  - address[ADDR_W-1]=1: registers selected by address[1:0]:
    - 0 CTRL (write-only): bit0 SWAP_REQ, bit1 CLEAR_REQ.
    - 1 STATUS (read-only): bit0 CLR_BUSY, bit1 SWAP_PEND, bit2 FRONT, bit3 ADDR_ERR (sticky, cleared by writing 1 to STATUS bit3).
    - 2 CLEAR_COLOR (R/W, PIXEL_W bits).
    - 3 reserved: reads 0, writes ignored.
- Storage: two banks of H_RES*V_RES x PIXEL_W, inferred synchronous RAM. Bank FRONT feeds VGA; bank ~FRONT takes writes.
- Pixel write, accepted (waitrequest=0):
  - In range: written to back bank; visible after the next swap.
  - Out of range: dropped, ADDR_ERR set.
- Pixel-space reads return 0 (no read-back path). Register reads: readdata registered, 1-cycle latency, waitrequest=0.
- waitrequest = chipselect & (write|read) & CLR_BUSY & pixel-space. Register access is never stalled.
- FSM states IDLE, CLEAR, SWAP_WAIT:
  - IDLE -> CLEAR on CLEAR_REQ. Counter loads 0; CLR_BUSY=1.
  - CLEAR: writes CLEAR_COLOR to back[cnt], one pixel per cycle. Done when cnt reaches H_RES*V_RES-1. Exit to SWAP_WAIT if SWAP_PEND, else IDLE.
  - IDLE -> SWAP_WAIT on SWAP_REQ; SWAP_PEND=1.
  - SWAP_WAIT: on vsync_pulse, FRONT toggles, SWAP_PEND=0, -> IDLE.
- Simultaneous CLEAR_REQ and SWAP_REQ in one write: clear runs first, then swap waits for a vsync strictly after clear completion.
- SWAP_REQ during CLEAR: latched into SWAP_PEND, no other effect.
- CLEAR_REQ while already CLEAR or SWAP_WAIT: ignored.
- Additional SWAP_REQ while pending: ignored. Never double-toggles.
- vsync_pulse in the same cycle as the CTRL write containing SWAP_REQ: swap waits for the next pulse.
- CLEAR_COLOR written mid-clear: takes effect from the following pixel.
- Pixel read port:
  - pix_rd with pix_x < H_RES and pix_y < V_RES: pix_rgb = front[pix_y*H_RES+pix_x] next cycle, pix_valid=1.
  - Out of range: pix_rgb=0, pix_valid=1.
  - No pix_rd: pix_valid=0 next cycle, pix_rgb holds its value.
  - The front bank is never written, so the displayed frame cannot tear.
- Reset (any state, including mid-clear):
  - FSM=IDLE, FRONT=0, SWAP_PEND=0, CLR_BUSY=0, ADDR_ERR=0, CLEAR_COLOR=0.
  - readdata=0, pix_rgb=0, pix_valid=0, waitrequest=0.
  - RAM contents are not cleared by reset; software issues CLEAR_REQ.
- Arithmetic: linear index = (y<<log-free multiply) computed as y*H_RES + x at index width clog2(H_RES*V_RES). Comparisons are unsigned.

Decomposition:
- Package vga_fb_pkg:
  - fb_state_t enum (IDLE, CLEAR, SWAP_WAIT).
  - Register offsets REG_CTRL=0, REG_STATUS=1, REG_CLRCOL=2.
  - CTRL/STATUS bit-position constants.
- Sub-module fb_bank_ram: simple dual-port synchronous RAM (one write port, one registered read port), parameters DEPTH and WIDTH. Instantiated twice.
- Bank-select muxing, FSM and register file stay in vga_fb_dbuf.

Test Plan:
- Reset, then STATUS read -> 0x0. pix_rd at (0,0) -> pix_valid=1 the next cycle.
- CLEAR_COLOR=0x00FF00, CTRL=0x2:
  - CLR_BUSY high for exactly H_RES*V_RES cycles.
  - Pixel write during clear sees waitrequest=1.
  - After CTRL=0x1 and a vsync, pix_rd (639,479) -> 0x00FF00.
- Write 0x123456 to index 641 (x=1, y=1), CTRL=0x1, vsync_pulse -> FRONT=1 and pix_rd (1,1) -> 0x123456. Before the vsync, (1,1) still returns the old front value.
- CTRL=0x3 (clear+swap), vsync_pulse mid-clear -> no toggle. Next vsync after CLR_BUSY falls -> FRONT toggles exactly once.
- Write to index 307200 -> no RAM change, STATUS bit3=1. Write 0x8 to STATUS -> bit3=0.
- Assert reset mid-clear -> CLR_BUSY=0, FSM IDLE next cycle. A new CTRL=0x2 restarts from index 0.
